// File: rtl/ksa_pkg.sv
// rtl/ksa_pkg.sv - shared slice width, FSM encoding and index-width helper for the wide sequential adder
package ksa_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ksa_wide_seq_adder_if.sv
// rtl/ksa_wide_seq_adder_if.sv - operand/result valid-ready bundle for the wide sequential adder
interface ksa_wide_seq_adder_if
  import ksa_pkg::*;
#(
  parameter int WORDS = 4
) ();

  localparam int W = SLICE_W * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/ksa16_slice.sv
// rtl/ksa16_slice.sv - combinational 16-bit Kogge-Stone adder slice with carry-in and carry-out
module ksa16_slice
  import ksa_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [15:0] g0, p0, g1, g2, g3, g4;
  logic [15:2] p1;
  logic [15:4] p2;
  logic [15:8] p3;

  // Carry-in is folded into bit 0's generate so the tree yields carries directly.
  assign p0 = a ^ b;
  assign g0 = {a[15:1] & b[15:1], (a[0] & b[0]) | (p0[0] & cin)};

  for (genvar i = 0; i < 16; i++) begin : g_lvl0
    if (i < 1) begin : g_pass
      assign g1[i] = g0[i];
    end else if (i < 2) begin : g_gray
      assign g1[i] = g0[i] | (p0[i] & g0[i-1]);
    end else begin : g_black
      assign g1[i] = g0[i] | (p0[i] & g0[i-1]);
      assign p1[i] = p0[i] & p0[i-1];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_lvl1
    if (i < 2) begin : g_pass
      assign g2[i] = g1[i];
    end else if (i < 4) begin : g_gray
      assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
    end else begin : g_black
      assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
      assign p2[i] = p1[i] & p1[i-2];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_lvl2
    if (i < 4) begin : g_pass
      assign g3[i] = g2[i];
    end else if (i < 8) begin : g_gray
      assign g3[i] = g2[i] | (p2[i] & g2[i-4]);
    end else begin : g_black
      assign g3[i] = g2[i] | (p2[i] & g2[i-4]);
      assign p3[i] = p2[i] & p2[i-4];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_lvl3
    if (i < 8) begin : g_pass
      assign g4[i] = g3[i];
    end else begin : g_gray
      assign g4[i] = g3[i] | (p3[i] & g3[i-8]);
    end
  end

  assign sum  = p0 ^ {g4[14:0], cin};
  assign cout = g4[15];

endmodule

// File: rtl/ksa_wide_seq_adder.sv
// rtl/ksa_wide_seq_adder.sv - WORDS*16-bit add/sub, one Kogge-Stone slice per cycle, valid/ready in and out
module ksa_wide_seq_adder
  import ksa_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ksa_wide_seq_adder_if.slave  bus
);

  localparam int W     = SLICE_W * WORDS;
  localparam int IDX_W = clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               msb_a_q, msb_a_d;
  logic               msb_b_q, msb_b_d;
  logic [W-1:0]       out_sum_q, out_sum_d;
  logic               out_cout_q, out_cout_d;
  logic               out_ovf_q, out_ovf_d;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  ksa16_slice u_slice (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    msb_a_d    = msb_a_q;
    msb_b_d    = msb_b_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    out_ovf_d  = out_ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
          carry_d = bus.in_cin | bus.in_sub;
          msb_a_d = bus.in_a[W-1];
          msb_b_d = b_d[W-1];
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = {{SLICE_W{1'b0}}, a_q[W-1:SLICE_W]};
        b_d     = {{SLICE_W{1'b0}}, b_q[W-1:SLICE_W]};
        sum_d   = {slice_sum, sum_q[W-1:SLICE_W]};
        carry_d = slice_cout;
        idx_d   = idx_q + IDX_W'(1);
        // Result registers only change here, so they hold across the next operation's RUN.
        if (idx_q == LAST_IDX) begin
          state_d    = DONE;
          out_sum_d  = {slice_sum, sum_q[W-1:SLICE_W]};
          out_cout_d = slice_cout;
          out_ovf_d  = (msb_a_q == msb_b_q) & (slice_sum[SLICE_W-1] != msb_a_q);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      msb_a_q    <= 1'b0;
      msb_b_q    <= 1'b0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      msb_a_q    <= msb_a_d;
      msb_b_q    <= msb_b_d;
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_ksa_wide_seq_adder.sv
// tb/tb_ksa_wide_seq_adder.sv - self-checking bench with arithmetic reference model and per-cycle output monitor
module tb_ksa_wide_seq_adder;

  localparam int WORDS = 4;
  localparam int W     = 64;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ksa_wide_seq_adder_if #(.WORDS(WORDS)) bus ();

  ksa_wide_seq_adder #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  res_t last_res = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    res_t         r;
    logic [W-1:0] be;
    logic [W:0]   full;
    be     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, be} + (W+1)'(sub | cin);
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == be[W-1]) && (r.sum[W-1] != a[W-1]);
    return r;
  endfunction

  // Result port must match the pending expectation while valid, and the last delivered result otherwise.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_res = '0;
    end else if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("mon_out_sum", bus.out_sum, exp_q[0].sum);
        check("mon_out_cout", bus.out_cout, exp_q[0].cout);
        check("mon_out_ovf", bus.out_ovf, exp_q[0].ovf);
        check("mon_in_ready_in_done", bus.in_ready, 0);
        if (bus.out_ready) begin
          last_res = exp_q[0];
          void'(exp_q.pop_front());
        end
      end
    end else begin
      check("mon_held_sum", bus.out_sum, last_res.sum);
      check("mon_held_cout", bus.out_cout, last_res.cout);
      check("mon_held_ovf", bus.out_ovf, last_res.ovf);
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input int hold, output res_t r);
    int edges;
    bit ok;
    r = model(a, b, cin, sub);
    @(posedge clk); #1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_cin    = cin;
    bus.in_sub    = sub;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    check("accept_timeout", 64'(ok), 1);
    if (!ok) begin
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(r);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    edges = 0;
    ok    = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1;
        break;
      end
    end
    check("latency_edges", 64'(edges), 64'(WORDS));
    if (!ok) return;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_a     = {$urandom, $urandom};
      bus.in_b     = {$urandom, $urandom};
      @(negedge clk);
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("post_ready_in_ready", bus.in_ready, 1);
    check("post_ready_out_valid", bus.out_valid, 0);
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input int hold,
                          input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf);
    res_t r;
    run_op(a, b, cin, sub, hold, r);
    check({name, "_model_sum"}, r.sum, e_sum);
    check({name, "_model_cout"}, r.cout, e_cout);
    check({name, "_model_ovf"}, r.ovf, e_ovf);
    check({name, "_dut_sum"}, bus.out_sum, e_sum);
    check({name, "_dut_cout"}, bus.out_cout, e_cout);
    check({name, "_dut_ovf"}, bus.out_ovf, e_ovf);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_sum", bus.out_sum, 0);
    check("reset_out_cout", bus.out_cout, 0);
    check("reset_out_ovf", bus.out_ovf, 0);

    directed("t1_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, 64'h0, 1'b1, 1'b0);
    directed("t2_sub", 64'h5, 64'h7, 1'b1, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    directed("t3_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
    directed("t4_chain", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 0,
             64'h0001_0000_0001_0000, 1'b0, 1'b0);
    directed("t5_backpressure", 64'h3, 64'h4, 1'b0, 1'b0, 10, 64'h7, 1'b0, 1'b0);
    directed("cin_only", 64'h0, 64'h0, 1'b1, 1'b0, 0, 64'h1, 1'b0, 1'b0);
    directed("sub_neg_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 0,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Abort an operation mid-flight with slice index 2 in progress.
    @(posedge clk); #1;
    bus.in_a      = 64'hDEAD_BEEF_CAFE_F00D;
    bus.in_b      = 64'h1111_2222_3333_4444;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("t6_in_ready_before", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_in_ready", bus.in_ready, 1);
    check("t6_out_sum", bus.out_sum, 0);
    check("t6_out_cout", bus.out_cout, 0);
    check("t6_out_ovf", bus.out_ovf, 0);
    directed("t6_after", 64'h1234, 64'h1, 1'b0, 1'b0, 0, 64'h1235, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (n % 10 == 3) a = '1;
      if (n % 10 == 7) b = a;
      run_op(a, b, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), r);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
